// File: rtl/ff_ga_pkg.sv
// ff_ga_pkg: shared types and constants for the ff_ga geometry accelerator.
//   fixed_t  : signed Q16.16 word
//   row4_t   : four words, element j = column j of one matrix row
//   mat4_t   : 4x4 matrix, [row][column]
//   state_t  : controller states
//   identity_mat() / col_of() : small matrix helpers
package ff_ga_pkg;

  localparam int FRAC_BITS = 16;

  typedef logic signed [31:0] fixed_t;
  typedef fixed_t [0:3]       row4_t;
  typedef fixed_t [0:3][0:3]  mat4_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_M = 2'd1,
    ST_LOAD_V = 2'd2,
    ST_READ   = 2'd3
  } state_t;

  localparam logic [31:0] ADDR_MATRIX = 32'd0;
  localparam logic [31:0] ADDR_VERTEX = 32'd1;
  localparam logic [31:0] ADDR_RESULT = 32'd2;

  // Identity for an arbitrary fractional width (1.0 = 1 << frac).
  function automatic mat4_t identity_mat(input int frac);
    mat4_t m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[i][i] = fixed_t'(1 << frac);
    end
    return m;
  endfunction

  localparam mat4_t IDENTITY = identity_mat(FRAC_BITS);

  // Extract column k as a row4_t (element i = row i).
  function automatic row4_t col_of(input mat4_t m, input logic [1:0] k);
    row4_t c;
    for (int i = 0; i < 4; i++) begin
      c[i] = m[i][k];
    end
    return c;
  endfunction

endpackage

// File: rtl/ff_ga_mat4_mul.sv
// mat4_mul: combinational 4x4 x 4x4 signed fixed-point multiply, p = a x b.
// Each element is the sum of four full 64-bit products, shifted arithmetic
// right by FRAC_BITS and truncated to 32 bits (wraps, rounds toward -inf).
//   a : left operand (always the composite transform)
//   b : right operand (incoming matrix or vertex batch)
//   p : product
module mat4_mul
  import ff_ga_pkg::*;
#(
  parameter int FRAC_BITS = ff_ga_pkg::FRAC_BITS
) (
  input  mat4_t a,
  input  mat4_t b,
  output mat4_t p
);

  // NOTE: combinational blocks use blocking '=' and assign every output
  // first, so no stale value can be held and no latch is inferred.
  always_comb begin
    p = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        logic signed [63:0] acc;
        acc = '0;
        for (int k = 0; k < 4; k++) begin
          acc = acc + 64'($signed(a[i][k])) * 64'($signed(b[k][j]));
        end
        p[i][j] = fixed_t'(acc >>> FRAC_BITS);
      end
    end
  end

endmodule

// File: rtl/ff_ga.sv
// ff_ga: fixed-function geometry accelerator.
// Holds a 4x4 composite transform C and multiplies incoming matrices
// (C <= C x M, R <= C x M) or vertex batches (R <= C x V) against it.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   addr     : command in IDLE (0 load matrix, 1 load vertices, 2 read);
//              at the row-3 edge, 2 chains straight into a read
//   data_in  : one matrix row per cycle, element j = column j
//   data_out : one result column per cycle in READ, else 0
//   rdy      : high only in IDLE
module ff_ga
  import ff_ga_pkg::*;
#(
  parameter int FRAC_BITS = ff_ga_pkg::FRAC_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  row4_t       data_in,
  output row4_t       data_out,
  output logic        rdy
);

  localparam mat4_t C_RESET = identity_mat(FRAC_BITS);

  state_t     state;
  mat4_t      c_mat;
  mat4_t      r_mat;
  row4_t      row_buf0, row_buf1, row_buf2;
  logic [1:0] row_cnt;
  logic [1:0] col_cnt;
  mat4_t      b_mat;
  mat4_t      prod;

  // Right operand: rows 0-2 from the buffer, row 3 straight from the bus so
  // the product is captured on the same edge as the last row.
  always_comb begin
    b_mat    = '0;
    b_mat[0] = row_buf0;
    b_mat[1] = row_buf1;
    b_mat[2] = row_buf2;
    b_mat[3] = data_in;
  end

  mat4_mul #(.FRAC_BITS(FRAC_BITS)) u_mul (
    .a (c_mat),
    .b (b_mat),
    .p (prod)
  );

  // NOTE: the row buffer is pure datapath storage that is always fully
  // rewritten before use, so it carries no reset.
  always_ff @(posedge clk) begin
    if ((state == ST_LOAD_M || state == ST_LOAD_V)) begin
      case (row_cnt)
        2'd0:    row_buf0 <= data_in;
        2'd1:    row_buf1 <= data_in;
        2'd2:    row_buf2 <= data_in;
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register sees
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      c_mat    <= C_RESET;
      r_mat    <= '0;
      row_cnt  <= '0;
      col_cnt  <= '0;
      rdy      <= 1'b1;
      data_out <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          row_cnt <= '0;
          col_cnt <= '0;
          if (addr == ADDR_MATRIX) begin
            state <= ST_LOAD_M;
            rdy   <= 1'b0;
          end else if (addr == ADDR_VERTEX) begin
            state <= ST_LOAD_V;
            rdy   <= 1'b0;
          end else if (addr == ADDR_RESULT) begin
            state    <= ST_READ;
            rdy      <= 1'b0;
            data_out <= col_of(r_mat, 2'd0);
          end
        end

        ST_LOAD_M, ST_LOAD_V: begin
          if (row_cnt != 2'd3) begin
            row_cnt <= row_cnt + 2'd1;
          end else begin
            row_cnt <= '0;
            col_cnt <= '0;
            r_mat   <= prod;
            if (state == ST_LOAD_M) begin
              c_mat <= prod;
            end
            // Chaining into READ shows the fresh product, not the old R.
            if (addr == ADDR_RESULT) begin
              state    <= ST_READ;
              data_out <= col_of(prod, 2'd0);
            end else begin
              state <= ST_IDLE;
              rdy   <= 1'b1;
            end
          end
        end

        ST_READ: begin
          if (col_cnt == 2'd3) begin
            state    <= ST_IDLE;
            rdy      <= 1'b1;
            col_cnt  <= '0;
            data_out <= '0;
          end else begin
            col_cnt  <= col_cnt + 2'd1;
            data_out <= col_of(r_mat, col_cnt + 2'd1);
          end
        end

        default: begin
          state    <= ST_IDLE;
          rdy      <= 1'b1;
          data_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ff_ga.sv
// tb_ff_ga: scoreboard bench for ff_ga. Each stimulus step pushes the
// outputs expected after its clock edge; a monitor pops and compares on
// the falling edge. Expected results come from a matrix-arithmetic model.
module tb_ff_ga;
  import ff_ga_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  row4_t       data_in;
  row4_t       data_out;
  logic        rdy;

  ff_ga #(.FRAC_BITS(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .rdy      (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic  rdy;
    row4_t out;
    string tag;
  } exp_t;

  exp_t  q[$];
  int    total = 0;
  int    bad   = 0;
  mat4_t c_mdl;
  mat4_t r_mdl;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: one expectation per stimulus edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check({e.tag, "_rdy"}, 128'(rdy), 128'(e.rdy));
      check({e.tag, "_data"}, data_out, e.out);
    end
  end

  // ---------------- reference model ----------------
  function automatic mat4_t mm(input mat4_t a, input mat4_t b);
    mat4_t  p;
    longint s;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++) begin
          s += longint'(a[i][k]) * longint'(b[k][j]);
        end
        p[i][j] = fixed_t'(s >>> 16);
      end
    end
    return p;
  endfunction

  function automatic row4_t col(input mat4_t m, input int k);
    row4_t c;
    for (int i = 0; i < 4; i++) c[i] = m[i][k];
    return c;
  endfunction

  function automatic fixed_t q16(input int v);
    return fixed_t'(v * 65536);
  endfunction

  function automatic fixed_t rand_fixed();
    if ($urandom_range(0, 3) == 0) return fixed_t'($urandom());
    return fixed_t'(int'($urandom_range(0, 32'h40000)) - 32'h20000);
  endfunction

  function automatic row4_t rand_row();
    row4_t r;
    for (int j = 0; j < 4; j++) r[j] = rand_fixed();
    return r;
  endfunction

  function automatic mat4_t rand_mat();
    mat4_t m;
    for (int i = 0; i < 4; i++) m[i] = rand_row();
    return m;
  endfunction

  // Addresses that must not start anything in IDLE.
  function automatic logic [31:0] noise_addr();
    case ($urandom_range(0, 3))
      0:       return 32'd3;
      1:       return 32'h0000_0100;
      2:       return 32'h8000_0002;
      default: return $urandom() | 32'h4;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  task automatic step(input logic [31:0] a, input row4_t d, input logic er,
                      input row4_t eo, input string tag);
    exp_t e;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #1;
    e.rdy = er;
    e.out = eo;
    e.tag = tag;
    q.push_back(e);
  endtask

  // Columns 1..3 of R, then the exit edge back to IDLE.
  task automatic read_tail(input logic [31:0] hold);
    for (int k = 1; k < 4; k++) step(hold, rand_row(), 1'b0, col(r_mdl, k), "read_col");
    step(hold, rand_row(), 1'b1, '0, "read_exit");
  endtask

  task automatic read(input logic [31:0] hold);
    step(ADDR_RESULT, rand_row(), 1'b0, col(r_mdl, 0), "read_col0");
    read_tail(hold);
  endtask

  task automatic load(input bit is_vtx, input mat4_t m, input logic [31:0] last_addr,
                      input logic [31:0] hold);
    step(is_vtx ? ADDR_VERTEX : ADDR_MATRIX, rand_row(), 1'b0, '0, "load_cmd");
    // addr is ignored on rows 0-2, including the value 2.
    for (int r = 0; r < 3; r++) step($urandom_range(0, 3), m[r], 1'b0, '0, "load_row");
    if (is_vtx) begin
      r_mdl = mm(c_mdl, m);
    end else begin
      c_mdl = mm(c_mdl, m);
      r_mdl = c_mdl;
    end
    if (last_addr == ADDR_RESULT) begin
      step(last_addr, m[3], 1'b0, col(r_mdl, 0), "chain_col0");
      read_tail(hold);
    end else begin
      step(last_addr, m[3], 1'b1, '0, "load_done");
    end
  endtask

  task automatic idle_noop();
    step(noise_addr(), rand_row(), 1'b1, '0, "idle_noop");
  endtask

  task automatic do_reset();
    exp_t e;
    rst = 1'b0;
    c_mdl = IDENTITY;
    r_mdl = '0;
    #1;
    e.rdy = 1'b1;
    e.out = '0;
    e.tag = "reset";
    q.push_back(e);
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    mat4_t p_m, t_m, v_m, m_m;

    addr    = '0;
    data_in = '0;
    do_reset();

    // Reset state readback: all zero columns.
    read(noise_addr());
    idle_noop();

    // Projection-like P loaded onto identity returns P exactly.
    p_m       = IDENTITY;
    p_m[2][2] = 32'hFFFF_FFFA;
    p_m[0][3] = q16(300);
    p_m[1][3] = q16(300);
    load(1'b0, p_m, noise_addr(), '0);
    read(noise_addr());

    // Translation T composed on the right.
    t_m       = IDENTITY;
    t_m[0][3] = q16(1);
    t_m[1][3] = q16(2);
    t_m[2][3] = q16(3);
    load(1'b0, t_m, noise_addr(), '0);
    read(noise_addr());

    // Vertex load chained directly into a read, then re-read.
    v_m       = '0;
    v_m[0][0] = q16(1);
    v_m[1][0] = q16(2);
    v_m[2][0] = q16(3);
    v_m[3][0] = q16(1);
    load(1'b1, v_m, ADDR_RESULT, noise_addr());
    read(noise_addr());

    // Reset in the middle of a matrix load, after two rows.
    step(ADDR_MATRIX, rand_row(), 1'b0, '0, "mid_cmd");
    step(32'd2, rand_row(), 1'b0, '0, "mid_row");
    step(32'd0, rand_row(), 1'b0, '0, "mid_row");
    @(negedge clk);
    #1;
    do_reset();
    m_m = rand_mat();
    load(1'b0, m_m, noise_addr(), '0);
    read(noise_addr());

    // addr held at 2 across the end of READ: one IDLE cycle, then re-entry.
    read(ADDR_RESULT);
    read(ADDR_RESULT);
    idle_noop();

    // Randomized mix.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0: load(1'b0, rand_mat(), ($urandom_range(0, 1) != 0) ? ADDR_RESULT : noise_addr(),
                ($urandom_range(0, 1) != 0) ? ADDR_RESULT : noise_addr());
        1: load(1'b1, rand_mat(), ($urandom_range(0, 1) != 0) ? ADDR_RESULT : noise_addr(),
                ($urandom_range(0, 1) != 0) ? ADDR_RESULT : noise_addr());
        2: read(($urandom_range(0, 1) != 0) ? ADDR_RESULT : noise_addr());
        default: idle_noop();
      endcase
    end

    // Let the monitor drain, bounded.
    for (int g = 0; g < 8 && q.size() > 0; g++) @(negedge clk);
    #1;
    check("drain", 128'(q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ff_ga.md
Name: ff_ga

Overview:
- Fixed-function geometry accelerator: holds a 4x4 composite transform (signed Q16.16) and multiplies incoming 4x4 matrices or vertex batches against it.
- Host interface: address-decoded command, 4-word write bus (one matrix row per cycle), 4-word read bus (one result column per cycle).
- Sits between host/CPU bus and rasterisation stage; typical use is loading projection, viewport and model transforms, then transforming vertices.

Parameters:
- FRAC_BITS, 16, fractional bits of the signed fixed-point format. Word width is fixed at 32.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  32  command select: 0 = load matrix, 1 = load vertices, 2 = read result, others = no-op.
- data_in  in  4x32 [0:3]  one row; element j = column j.
- data_out  out  4x32 [0:3]  one result column; element i = row i.
- rdy  out  1  high only in IDLE.

Behaviour:
- Format: signed two's-complement Q16.16. 1.0 = 0x00010000; -6/65536 = 0xFFFFFFFA.
- Element product: full 64-bit signed product. Each dot product sums four 64-bit products, then shifts arithmetic-right by FRAC_BITS and keeps the low 32 bits. Overflow wraps, no saturation; truncation is toward negative infinity.
- Registers: composite C (4x4), result R (4x4), row buffer rows 0-2, 2-bit row counter, 2-bit column counter, state.
- Reset (async, rst=0): state IDLE; C = identity; R = 0; counters = 0; rdy = 1; data_out = 0. A reset mid-load or mid-read discards the partial transfer.
- States: IDLE, LOAD_M, LOAD_V, READ.
- IDLE: rdy = 1. At posedge, addr 0 -> LOAD_M, 1 -> LOAD_V, 2 -> READ, else stay. Row and column counters cleared.
- LOAD_M / LOAD_V: rdy = 0. Sample data_in as row 0,1,2,3 on four consecutive posedges. The first sample is the first posedge after entry, and addr is ignored while loading.
- On the row-3 edge, compute the product from buffered rows 0-2 plus the live data_in as row 3 (no extra latency):
  - LOAD_M: C <= C x M and R <= C x M (right-multiply, OpenGL order).
  - LOAD_V: R <= C x V, where each column of V is one homogeneous vertex; C unchanged.
- Next state after row 3: READ if addr == 2 at that edge, else IDLE. Result is therefore readable immediately after a vertex load.
- READ: rdy = 0. data_out = column k of R, where k = column counter. Column 0 is valid throughout the first cycle after entry; k increments each posedge. After column 3 -> IDLE unconditionally, even if addr is still 2.
- data_out = 0 outside READ.
- Latency: a matrix load takes 4 cycles in LOAD state. The first read column appears 1 cycle after the READ-entering edge.
- Unknown addr values in IDLE are ignored, with no side effects.

Decomposition:
- Package ff_ga_pkg: typedef fixed_t (logic signed [31:0]), typedef mat4_t ([0:3][0:3] fixed_t), typedef row4_t, constants ADDR_MATRIX=0, ADDR_VERTEX=1, ADDR_RESULT=2, FRAC_BITS, IDENTITY.
- State enum lives in the package.
- Sub-module mat4_mul: combinational 4x4 by 4x4 fixed-point multiply, 16 dot products. The top instantiates one copy shared by both load types; the left operand is always C.

Test Plan:
- Reset, then read result: four columns all 0x00000000; rdy = 1 in IDLE.
- Load P (diagonal 1,1,0xFFFFFFFA,1; col3 = 300.0, 300.0, 0, 1.0) after reset, then read: returns P exactly, because C was identity.
- Then load T (identity with col3 = 1.0, 2.0, 3.0, 1.0) and read. Col3 must be 301.0, 302.0, 0xFFFFFFEE, 1.0; diagonal unchanged; all other elements 0.
- Then load vertex V (col0 = 1.0, 2.0, 3.0, 1.0, other columns 0) with addr=2 on the final row edge. The first read column must be 302.0, 304.0, 0xFFFFFFDC, 1.0; remaining columns 0; C unchanged on a re-read.
- Assert rst low mid-LOAD_M after two rows: state IDLE and C = identity. A following full load of M, then read, returns M.
- With addr held at 2 across the end of READ: READ lasts exactly 4 cycles, then IDLE for one cycle with rdy = 1, before re-entry.
